shared_counters_scheduler: RTL and testbench

SHARED_COUNTERS_SCHEDULER -- requirements
Module: shared_counters_scheduler

---
 rtl/shared_counters_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_shared_counters_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_counters_scheduler.sv
// Round-robin front end for a shared_counters instance.
// Serialises inc/alloc/dealloc/read requests and streams read beats back.
module shared_counters_scheduler #(
  parameter int n = 10,
  parameter int g = 4,
  parameter int R = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [R-1:0]                  req_valid,
  input  logic [3*R-1:0]                req_op,
  input  logic [R*$clog2(n)-1:0]        req_id,
  input  logic [R*($clog2(n)+1)-1:0]    req_size,
  output logic [R-1:0]                  req_ready,
  output logic [2:0]                    sc_command,
  output logic [$clog2(n)-1:0]          sc_id,
  output logic [31:0]                   sc_size,
  input  logic [$clog2(n):0]            sc_alloc_id,
  input  logic                          sc_alloc_valid,
  input  logic [g-1:0]                  sc_rdata,
  input  logic                          sc_rvalid,
  input  logic                          sc_last,
  output logic                          resp_valid,
  output logic [R-1:0]                  resp_owner,
  output logic                          resp_ok,
  output logic [$clog2(n):0]            resp_alloc_id,
  output logic                          rd_valid,
  output logic [g-1:0]                  rd_data,
  output logic                          rd_last,
  output logic [R-1:0]                  rd_owner
);

  localparam int IW = $clog2(n);
  localparam int SW = IW + 1;
  localparam int PW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = $clog2(n + 2) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_ALLOC = 3'b010;
  localparam logic [2:0] OP_DEALC = 3'b011;
  localparam logic [2:0] OP_READ  = 3'b101;

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [2:0]    op_q;
  logic [IW-1:0] id_q;
  logic [SW-1:0] size_q;
  logic [R-1:0]  owner_q;
  logic          ok_q;
  logic [SW-1:0] alloc_id_q;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] cyc_cnt;

  logic          found;
  logic [PW-1:0] win;
  logic          accept;
  logic [2:0]    w_op;
  logic [IW-1:0] w_id;
  logic [SW-1:0] w_size;
  logic          w_op_ok;
  logic          w_legal;

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < R; k++) begin
      idx = (int'(rr_ptr) + k) % R;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign w_op   = req_op[int'(win)*3 +: 3];
  assign w_id   = req_id[int'(win)*IW +: IW];
  assign w_size = req_size[int'(win)*SW +: SW];

  always_comb begin
    w_op_ok = 1'b0;
    unique case (1'b1)
      (w_op == OP_INC),
      (w_op == OP_DEALC),
      (w_op == OP_READ):  w_op_ok = 1'b1;
      (w_op == OP_ALLOC): w_op_ok = (w_size != '0) && (32'(w_size) <= n);
      default:            w_op_ok = 1'b0;
    endcase
  end

  assign w_legal = w_op_ok && (32'(w_id) < n);
  assign accept  = (state == S_IDLE) && found && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  logic cmd_on;
  assign cmd_on     = (state == S_ISSUE) || (state == S_READ);
  assign sc_command = cmd_on ? op_q : 3'b000;
  assign sc_id      = cmd_on ? id_q : '0;
  assign sc_size    = cmd_on ? 32'(size_q) : 32'd0;

  assign resp_valid    = (state == S_RESP);
  assign resp_owner    = resp_valid ? owner_q : '0;
  assign resp_ok       = resp_valid && ok_q;
  assign resp_alloc_id = resp_valid ? alloc_id_q : '0;

  // a read ends on sc_last, on the top subcounter, or after n+1 cycles
  logic reach;
  logic timeout;
  logic beat_term;
  logic read_done;
  assign reach     = (32'(id_q) + 32'(beat_cnt) + 1) >= n;
  assign timeout   = (32'(cyc_cnt) == n);
  assign beat_term = sc_rvalid && (sc_last || reach || timeout);
  assign read_done = beat_term || timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      op_q       <= '0;
      id_q       <= '0;
      size_q     <= '0;
      owner_q    <= '0;
      ok_q       <= 1'b0;
      alloc_id_q <= '0;
      beat_cnt   <= '0;
      cyc_cnt    <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      rd_owner   <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      rd_owner <= '0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            op_q       <= w_op;
            id_q       <= w_id;
            size_q     <= w_size;
            owner_q    <= req_ready;
            ok_q       <= w_legal;
            alloc_id_q <= '0;
            beat_cnt   <= '0;
            cyc_cnt    <= '0;
            rr_ptr     <= (int'(win) == R - 1) ? '0 : win + 1'b1;
            state      <= w_legal ? S_ISSUE : S_RESP;
          end
        end
        S_ISSUE: begin
          if (op_q == OP_ALLOC) begin
            ok_q       <= sc_alloc_valid;
            alloc_id_q <= sc_alloc_valid ? sc_alloc_id : '0;
          end
          state <= (op_q == OP_READ) ? S_READ : S_RESP;
        end
        S_READ: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          if (sc_rvalid) begin
            rd_valid <= 1'b1;
            rd_data  <= sc_rdata;
            rd_last  <= beat_term;
            rd_owner <= owner_q;
            beat_cnt <= beat_cnt + 1'b1;
          end else if (timeout) begin
            rd_valid <= 1'b1;
            rd_last  <= 1'b1;
            rd_owner <= owner_q;
            ok_q     <= 1'b0;
          end
          if (read_done) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_counters_scheduler.sv
// Bench for shared_counters_scheduler: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_shared_counters_scheduler;

  localparam int N  = 10;
  localparam int G  = 4;
  localparam int R  = 4;
  localparam int IW = 4;
  localparam int SW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [R-1:0]      req_valid;
  logic [3*R-1:0]    req_op;
  logic [R*IW-1:0]   req_id;
  logic [R*SW-1:0]   req_size;
  logic [R-1:0]      req_ready;
  logic [2:0]        sc_command;
  logic [IW-1:0]     sc_id;
  logic [31:0]       sc_size;
  logic [SW-1:0]     sc_alloc_id;
  logic              sc_alloc_valid;
  logic [G-1:0]      sc_rdata;
  logic              sc_rvalid;
  logic              sc_last;
  logic              resp_valid;
  logic [R-1:0]      resp_owner;
  logic              resp_ok;
  logic [SW-1:0]     resp_alloc_id;
  logic              rd_valid;
  logic [G-1:0]      rd_data;
  logic              rd_last;
  logic [R-1:0]      rd_owner;

  shared_counters_scheduler #(.n(N), .g(G), .R(R)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op),
    .req_id(req_id), .req_size(req_size),
    .req_ready(req_ready),
    .sc_command(sc_command), .sc_id(sc_id), .sc_size(sc_size),
    .sc_alloc_id(sc_alloc_id), .sc_alloc_valid(sc_alloc_valid),
    .sc_rdata(sc_rdata), .sc_rvalid(sc_rvalid), .sc_last(sc_last),
    .resp_valid(resp_valid), .resp_owner(resp_owner),
    .resp_ok(resp_ok), .resp_alloc_id(resp_alloc_id),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .rd_owner(rd_owner)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rr       = 0;
  int bv[N+1];
  int bd[N+1];
  int bl[N+1];

  task automatic tick();
    logic [R-1:0] acc;
    acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
    #1;
  endtask

  task automatic set_req(input int r, input int op,
                         input int id, input int size);
    req_valid[r]           = 1'b1;
    req_op[r*3 +: 3]       = 3'(op);
    req_id[r*IW +: IW]     = IW'(id);
    req_size[r*SW +: SW]   = SW'(size);
  endtask

  task automatic clear_beats();
    for (int c = 0; c <= N; c++) begin
      bv[c] = 0; bd[c] = 0; bl[c] = 0;
    end
  endtask

  function automatic int pick(input logic [R-1:0] m);
    for (int k = 0; k < R; k++)
      if (m[(rr + k) % R]) return (rr + k) % R;
    return -1;
  endfunction

  // Full transaction for requester w, expected to win this IDLE cycle.
  task automatic do_txn(input int w, input int op, input int id,
                        input int size, input int av, input int aid);
    logic [R-1:0]       oh;
    logic [G-1:0]       pd;
    logic [1+G+1+R-1:0] exp_rd;
    bit   legal, pv, pl, done;
    int   exp_ok, exp_aid, beats;
    oh = '0;
    oh[w] = 1'b1;
    legal = (op == 1 || op == 2 || op == 3 || op == 5) && id < N &&
            !(op == 2 && (size == 0 || size > N));
    exp_ok  = (op == 2) ? av : 1;
    exp_aid = (op == 2 && av != 0) ? aid : 0;
    #1;
    checks++;
    if (req_ready !== oh) begin
      failures++;
      $display("FAIL arb: req_ready=%b want %b", req_ready, oh);
    end
    checks++;
    if (sc_command !== 3'b000) begin
      failures++;
      $display("FAIL idle_cmd: sc_command=%b want 000", sc_command);
    end
    rr = (w + 1) % R;
    tick();
    if (!legal) begin
      #1;
      checks++;
      if ({resp_valid, resp_ok, resp_owner, sc_command} !==
          {1'b1, 1'b0, oh, 3'b000}) begin
        failures++;
        $display("FAIL reject: v=%b ok=%b own=%b cmd=%b want 1 0 %b 000",
                 resp_valid, resp_ok, resp_owner, sc_command, oh);
      end
      tick();
      return;
    end
    sc_alloc_valid = 1'(av);
    sc_alloc_id    = SW'(aid);
    #1;
    checks++;
    if ({sc_command, sc_id, sc_size, req_ready} !==
        {3'(op), IW'(id), 32'(size), 4'b0000}) begin
      failures++;
      $display("FAIL issue: cmd=%b id=%0d size=%0d rdy=%b want %b %0d %0d 0000",
               sc_command, sc_id, sc_size, req_ready, 3'(op), id, size);
    end
    tick();
    sc_alloc_valid = 1'b0;
    sc_alloc_id    = '0;
    pv = 0; pd = '0; pl = 0;
    if (op == 5) begin
      beats = 0;
      done  = 0;
      for (int c = 0; c <= N && !done; c++) begin
        sc_rvalid = 1'(bv[c]);
        sc_rdata  = G'(bd[c]);
        sc_last   = 1'(bl[c]);
        #1;
        checks++;
        if (sc_command !== 3'b101) begin
          failures++;
          $display("FAIL read_cmd: cyc %0d sc_command=%b want 101",
                   c, sc_command);
        end
        exp_rd = {pv, pd, pl, (pv ? oh : {R{1'b0}})};
        checks++;
        if ({rd_valid, rd_data, rd_last, rd_owner} !== exp_rd) begin
          failures++;
          $display("FAIL rd_beat: cyc %0d got %b want %b", c,
                   {rd_valid, rd_data, rd_last, rd_owner}, exp_rd);
        end
        if (bv[c] != 0) begin
          beats++;
          pv = 1; pd = G'(bd[c]);
          pl = (bl[c] != 0) || (id + beats >= N) || (c == N);
          done = pl;
        end else if (c == N) begin
          pv = 1; pd = '0; pl = 1; exp_ok = 0; done = 1;
        end else begin
          pv = 0; pd = '0; pl = 0;
        end
        tick();
      end
      sc_rvalid = 1'b0;
      sc_rdata  = '0;
      sc_last   = 1'b0;
    end
    #1;
    if (op == 5) begin
      exp_rd = {pv, pd, pl, (pv ? oh : {R{1'b0}})};
      checks++;
      if ({rd_valid, rd_data, rd_last, rd_owner} !== exp_rd) begin
        failures++;
        $display("FAIL rd_final: got %b want %b",
                 {rd_valid, rd_data, rd_last, rd_owner}, exp_rd);
      end
    end
    checks++;
    if ({resp_valid, resp_ok, resp_alloc_id, resp_owner, sc_command} !==
        {1'b1, 1'(exp_ok), SW'(exp_aid), oh, 3'b000}) begin
      failures++;
      $display("FAIL resp: v=%b ok=%b aid=%0d own=%b cmd=%b want 1 %0d %0d %b 000",
               resp_valid, resp_ok, resp_alloc_id, resp_owner,
               sc_command, exp_ok, exp_aid, oh);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_id = '0; req_size = '0;
    sc_alloc_id = '0; sc_alloc_valid = 1'b0;
    sc_rdata = '0; sc_rvalid = 1'b0; sc_last = 1'b0;
    tick();
    tick();
    set_req(1, 1, 2, 0);
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready: req_ready=%b want 0000", req_ready);
    end
    tick();
    req_valid = '0;
    rst = 1'b0;
    #1;
    checks++;
    if ({sc_command, sc_id, sc_size, resp_valid, resp_owner, resp_ok,
         resp_alloc_id, rd_valid, rd_data, rd_last, rd_owner} !== '0) begin
      failures++;
      $display("FAIL reset_outs: cmd=%b rv=%b rdv=%b own=%b want all 0",
               sc_command, resp_valid, rd_valid, rd_owner);
    end
    rr = 0;
    tick();
  endtask

  task automatic test_alloc();
    set_req(0, 2, 0, 3);
    do_txn(0, 2, 0, 3, 1, 0);
    set_req(3, 2, 0, 10);
    do_txn(3, 2, 0, 10, 1, 5);
    set_req(1, 2, 0, 4);
    do_txn(1, 2, 0, 4, 0, 7);
  endtask

  task automatic test_round_robin();
    set_req(0, 2, 0, 3);
    do_txn(0, 2, 0, 3, 1, 0);
    set_req(0, 1, 2, 0);
    set_req(2, 1, 4, 0);
    do_txn(2, 1, 4, 0, 0, 0);
    do_txn(0, 1, 2, 0, 0, 0);
  endtask

  task automatic test_read();
    clear_beats();
    bv[0] = 1; bd[0] = 5;
    bv[1] = 1; bd[1] = 3;
    bv[2] = 1; bd[2] = 9; bl[2] = 1;
    set_req(1, 5, 0, 0);
    do_txn(pick(4'b0010), 5, 0, 0, 0, 0);
    clear_beats();
    for (int c = 0; c <= N; c++) begin
      bv[c] = 1; bd[c] = c + 4;
    end
    set_req(2, 5, 7, 0);
    do_txn(pick(4'b0100), 5, 7, 0, 0, 0);
    clear_beats();
    set_req(3, 5, 0, 0);
    do_txn(pick(4'b1000), 5, 0, 0, 0, 0);
  endtask

  task automatic test_reject();
    set_req(3, 4, 1, 0);
    do_txn(pick(4'b1000), 4, 1, 0, 0, 0);
    set_req(0, 5, 12, 0);
    do_txn(pick(4'b0001), 5, 12, 0, 0, 0);
    set_req(2, 2, 0, 0);
    do_txn(pick(4'b0100), 2, 0, 0, 1, 1);
    set_req(1, 2, 0, 11);
    do_txn(pick(4'b0010), 2, 0, 11, 1, 1);
  endtask

  task automatic test_reset_mid_read();
    set_req(2, 5, 0, 0);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL mid_arb: req_ready=%b want 0100", req_ready);
    end
    tick();
    tick();
    sc_rvalid = 1'b1; sc_rdata = 4'd6;
    tick();
    sc_rdata = 4'd7;
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_valid, rd_data} !== {1'b1, 4'd6}) begin
      failures++;
      $display("FAIL mid_beat1: rd_valid=%b rd_data=%0d want 1 6",
               rd_valid, rd_data);
    end
    tick();
    rst = 1'b0;
    sc_rvalid = 1'b0; sc_rdata = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({rd_valid, sc_command, resp_valid} !== {1'b0, 3'b000, 1'b0}) begin
        failures++;
        $display("FAIL mid_reset: cyc %0d rdv=%b cmd=%b rv=%b want 0 000 0",
                 k, rd_valid, sc_command, resp_valid);
      end
      tick();
    end
    rr = 0;
  endtask

  task automatic test_random();
    int opt[12] = '{1, 2, 3, 5, 1, 2, 5, 5, 0, 4, 6, 7};
    int rop[R];
    int rid[R];
    int rsz[R];
    logic [R-1:0] pend;
    int w;
    for (int round = 0; round < 40; round++) begin
      pend = R'($urandom_range(1, (1 << R) - 1));
      for (int r = 0; r < R; r++) begin
        rop[r] = opt[$urandom_range(0, 11)];
        rid[r] = $urandom_range(0, 12);
        rsz[r] = $urandom_range(0, 11);
        if (pend[r]) set_req(r, rop[r], rid[r], rsz[r]);
      end
      while (pend != '0) begin
        w = pick(pend);
        for (int c = 0; c <= N; c++) begin
          bv[c] = ($urandom_range(0, 99) < 60) ? 1 : 0;
          bd[c] = $urandom_range(0, 15);
          bl[c] = ($urandom_range(0, 99) < 10) ? 1 : 0;
        end
        do_txn(w, rop[w], rid[w], rsz[w],
               $urandom_range(0, 1), $urandom_range(0, 31));
        pend[w] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_round_robin();
    test_read();
    test_reject();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
